// File: rtl/cpu_writeback_stage.sv
// rtl/cpu_writeback_stage.sv - register-file write-port arbiter for main-pipe and multiplier writebacks
//
// Merges the main-pipe writeback (always highest priority) with multiplier
// results onto the single register-file write port. Multiplier results that
// lose arbitration wait in a small in-order queue; a younger main-pipe write
// to the same register squashes any queued multiplier result for it.
//
// Build option: CPU_WB_MUL_BYPASS_EN - when defined, a multiplier result that
// arrives with an empty queue and no main write goes straight to the write port.
//
// Ports:
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   reg_write       main-pipe write request
//   mem_to_reg      select mem_data (1) or alu_data (0) as main write data
//   reg_dest        main-pipe destination register
//   mem_data        load result
//   alu_data        ALU result
//   writeback_mul   multiplier result valid
//   rd_id           multiplier destination register
//   mul_result      multiplier result data
//   mul_stall       multiplier must hold its outputs (queue full)
//   rf_we           register-file write enable (registered)
//   rf_waddr        register-file write address (registered)
//   rf_wdata        register-file write data (registered)
//   pending_mask    one bit per register with a valid queued multiplier result

`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif
`ifndef NUM_REGS
`define NUM_REGS 32
`endif

module cpu_writeback_stage #(
    parameter int MUL_QUEUE_DEPTH = 2,
    localparam int RW = $clog2(`NUM_REGS),
    localparam int W  = `REG_WIDTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              reg_write,
    input  logic              mem_to_reg,
    input  logic [RW-1:0]     reg_dest,
    input  logic [W-1:0]      mem_data,
    input  logic [W-1:0]      alu_data,
    input  logic              writeback_mul,
    input  logic [RW-1:0]     rd_id,
    input  logic [W-1:0]      mul_result,
    output logic              mul_stall,
    output logic              rf_we,
    output logic [RW-1:0]     rf_waddr,
    output logic [W-1:0]      rf_wdata,
    output logic [`NUM_REGS-1:0] pending_mask
);

    localparam int PW = (MUL_QUEUE_DEPTH > 1) ? $clog2(MUL_QUEUE_DEPTH) : 1;
    localparam int CW = $clog2(MUL_QUEUE_DEPTH + 1);
    localparam logic [PW-1:0] LAST_PTR = PW'(MUL_QUEUE_DEPTH - 1);
    localparam logic [CW-1:0] FULL_CNT = CW'(MUL_QUEUE_DEPTH);

    logic [MUL_QUEUE_DEPTH-1:0] q_valid;
    logic [RW-1:0]              q_rd   [MUL_QUEUE_DEPTH];
    logic [W-1:0]               q_data [MUL_QUEUE_DEPTH];
    logic [PW-1:0]              head;
    logic [PW-1:0]              tail;
    logic [CW-1:0]              count;

    logic [W-1:0] main_data;
    logic         mul_accept;
    logic         q_nonempty;
    logic         head_valid;
    logic         mul_squash;
    logic         mul_direct;
    logic         pop;
    logic         push;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    assign main_data  = mem_to_reg ? mem_data : alu_data;
    assign mul_stall  = (count == FULL_CNT);
    assign mul_accept = writeback_mul && !mul_stall;
    assign q_nonempty = (count != '0);
    assign head_valid = q_nonempty && q_valid[head];
    // The main pipe is the younger producer, so a same-cycle multiplier result
    // for the same register is stale and dropped.
    assign mul_squash = reg_write && (rd_id == reg_dest);

`ifdef CPU_WB_MUL_BYPASS_EN
    assign mul_direct = mul_accept && !reg_write && !q_nonempty;
`else
    assign mul_direct = 1'b0;
`endif

    // A squashed (invalid) head is retired silently every cycle it is at the head;
    // a valid head only leaves when the main pipe is not using the port.
    assign pop  = q_nonempty && (!q_valid[head] || !reg_write);
    assign push = mul_accept && !mul_squash && !mul_direct;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            q_valid  <= '0;
        end else begin
            rf_we <= 1'b0;
            if (reg_write) begin
                rf_we    <= 1'b1;
                rf_waddr <= reg_dest;
                rf_wdata <= main_data;
            end else if (head_valid) begin
                rf_we    <= 1'b1;
                rf_waddr <= q_rd[head];
                rf_wdata <= q_data[head];
            end
`ifdef CPU_WB_MUL_BYPASS_EN
            else if (mul_direct) begin
                rf_we    <= 1'b1;
                rf_waddr <= rd_id;
                rf_wdata <= mul_result;
            end
`endif

            for (int i = 0; i < MUL_QUEUE_DEPTH; i++) begin
                if (reg_write && (q_rd[i] == reg_dest)) begin
                    q_valid[i] <= 1'b0;
                end
            end
            if (pop) begin
                q_valid[head] <= 1'b0;
                head          <= ptr_inc(head);
            end
            // Push and pop never hit the same slot: a push needs count<DEPTH,
            // a pop needs count>0, and they only coincide on distinct slots.
            if (push) begin
                q_valid[tail] <= 1'b1;
                tail          <= ptr_inc(tail);
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Payload storage needs no reset: entries are qualified by q_valid.
    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[tail]   <= rd_id;
            q_data[tail] <= mul_result;
        end
    end

    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < MUL_QUEUE_DEPTH; i++) begin
            if (q_valid[i]) begin
                pending_mask[q_rd[i]] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_writeback_stage.sv
// tb/tb_cpu_writeback_stage.sv - self-checking bench for cpu_writeback_stage

`ifndef REG_WIDTH
`define REG_WIDTH 32
`endif
`ifndef NUM_REGS
`define NUM_REGS 32
`endif

module tb_cpu_writeback_stage;

    localparam int RW = $clog2(`NUM_REGS);
    localparam int W  = `REG_WIDTH;
    localparam int NR = `NUM_REGS;

    logic              clk;
    logic              rst_n;
    logic              reg_write;
    logic              mem_to_reg;
    logic [RW-1:0]     reg_dest;
    logic [W-1:0]      mem_data;
    logic [W-1:0]      alu_data;
    logic              writeback_mul;
    logic [RW-1:0]     rd_id;
    logic [W-1:0]      mul_result;
    logic              mul_stall;
    logic              rf_we;
    logic [RW-1:0]     rf_waddr;
    logic [W-1:0]      rf_wdata;
    logic [NR-1:0]     pending_mask;

    cpu_writeback_stage #(.MUL_QUEUE_DEPTH(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .reg_write     (reg_write),
        .mem_to_reg    (mem_to_reg),
        .reg_dest      (reg_dest),
        .mem_data      (mem_data),
        .alu_data      (alu_data),
        .writeback_mul (writeback_mul),
        .rd_id         (rd_id),
        .mul_result    (mul_result),
        .mul_stall     (mul_stall),
        .rf_we         (rf_we),
        .rf_waddr      (rf_waddr),
        .rf_wdata      (rf_wdata),
        .pending_mask  (pending_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [RW-1:0] a;
        logic [W-1:0]  d;
    } wr_t;
    wr_t sb[$];

    typedef struct {
        logic          rw;
        logic          mtr;
        logic [RW-1:0] rd;
        logic [W-1:0]  md;
        logic [W-1:0]  ad;
        logic          exp_we;
        logic [W-1:0]  exp_data;
    } vec_t;
    vec_t vecs[6];

    function automatic vec_t mk(input logic rw, input logic mtr, input int rd,
                                input int md, input int ad, input logic ew, input int ed);
        vec_t v;
        v.rw = rw; v.mtr = mtr; v.rd = RW'(rd);
        v.md = W'(md); v.ad = W'(ad);
        v.exp_we = ew; v.exp_data = W'(ed);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic expect_wr(input int a, input int d);
        wr_t e;
        e.a = RW'(a);
        e.d = W'(d);
        sb.push_back(e);
    endtask

    task automatic drive(input logic rw, input logic mtr, input int rd, input int md,
                         input int ad, input logic mv, input int mrd, input int mres);
        reg_write     = rw;
        mem_to_reg    = mtr;
        reg_dest      = RW'(rd);
        mem_data      = W'(md);
        alu_data      = W'(ad);
        writeback_mul = mv;
        rd_id         = RW'(mrd);
        mul_result    = W'(mres);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 0, 0, 0, 1'b0, 0, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Every register-file write is matched in order against the scoreboard.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && rf_we === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write actual=%0h:%0h required=none", rf_waddr, rf_wdata);
            end else begin
                wr_t e;
                e = sb.pop_front();
                if (rf_waddr !== e.a || rf_wdata !== e.d) begin
                    errors++;
                    $display("FAIL sb_write actual=%0h:%0h required=%0h:%0h",
                             rf_waddr, rf_wdata, e.a, e.d);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        idle();
        vecs[0] = mk(1'b1, 1'b0, 5,  'hDEAD, 'h1234, 1'b1, 'h1234);
        vecs[1] = mk(1'b1, 1'b1, 5,  'hBEEF, 'h1234, 1'b1, 'hBEEF);
        vecs[2] = mk(1'b1, 1'b1, 31, 'h5A5A, 'h0,    1'b1, 'h5A5A);
        vecs[3] = mk(1'b0, 1'b1, 9,  'h99,   'h98,   1'b0, 'h0);
        vecs[4] = mk(1'b1, 1'b0, 0,  'h11,   'hC0DE, 1'b1, 'hC0DE);
        vecs[5] = mk(1'b1, 1'b0, 17, 'h22,   'h0,    1'b1, 'h0);

        tick();
        tick();
        chk("reset_rf_we", 64'(rf_we), 64'd0);
        chk("reset_rf_waddr", 64'(rf_waddr), 64'd0);
        chk("reset_rf_wdata", 64'(rf_wdata), 64'd0);
        chk("reset_mul_stall", 64'(mul_stall), 64'd0);
        chk("reset_pending_mask", 64'(pending_mask), 64'd0);
        rst_n = 1'b1;
        tick();

        // Main-pipe writes: data mux and address pass-through.
        for (int i = 0; i < 6; i++) begin
            drive(vecs[i].rw, vecs[i].mtr, int'(vecs[i].rd), int'(vecs[i].md),
                  int'(vecs[i].ad), 1'b0, 0, 0);
            if (vecs[i].exp_we) expect_wr(int'(vecs[i].rd), int'(vecs[i].exp_data));
            tick();
            chk($sformatf("vec%0d_rf_we", i), 64'(rf_we), 64'(vecs[i].exp_we));
            if (vecs[i].exp_we) begin
                chk($sformatf("vec%0d_rf_waddr", i), 64'(rf_waddr), 64'(vecs[i].rd));
                chk($sformatf("vec%0d_rf_wdata", i), 64'(rf_wdata), 64'(vecs[i].exp_data));
            end
        end
        idle();
        tick();

        // Lone multiplier result on an idle pipe.
        drive(1'b0, 1'b0, 0, 0, 0, 1'b1, 3, 'h77);
        expect_wr(3, 'h77);
        tick();
        idle();
`ifdef CPU_WB_MUL_BYPASS_EN
        chk("mul_bypass_we", 64'(rf_we), 64'd1);
        chk("mul_bypass_mask", 64'(pending_mask), 64'd0);
        tick();
`else
        chk("mul_queued_we", 64'(rf_we), 64'd0);
        chk("mul_queued_mask", 64'(pending_mask), 64'(1 << 3));
        tick();
        chk("mul_drain_we", 64'(rf_we), 64'd1);
        chk("mul_drain_addr", 64'(rf_waddr), 64'd3);
        chk("mul_drain_mask", 64'(pending_mask), 64'd0);
`endif
        tick();

        // Four main writes against three multiplier results; queue fills at two.
        drive(1'b1, 1'b0, 10, 0, 'h100, 1'b1, 7, 'hA1);
        expect_wr(10, 'h100);
        tick();
        chk("burst0_stall", 64'(mul_stall), 64'd0);
        chk("burst0_mask", 64'(pending_mask), 64'(1 << 7));
        drive(1'b1, 1'b0, 11, 0, 'h101, 1'b1, 8, 'hA2);
        expect_wr(11, 'h101);
        tick();
        chk("burst1_stall", 64'(mul_stall), 64'd1);
        chk("burst1_mask", 64'(pending_mask), 64'((1 << 7) | (1 << 8)));
        drive(1'b1, 1'b0, 12, 0, 'h102, 1'b1, 9, 'hA3);
        expect_wr(12, 'h102);
        tick();
        chk("burst2_stall", 64'(mul_stall), 64'd1);
        drive(1'b1, 1'b0, 13, 0, 'h103, 1'b1, 9, 'hA3);
        expect_wr(13, 'h103);
        tick();
        chk("burst3_stall", 64'(mul_stall), 64'd1);
        chk("burst3_addr", 64'(rf_waddr), 64'd13);
        drive(1'b0, 1'b0, 0, 0, 0, 1'b1, 9, 'hA3);
        expect_wr(7, 'hA1);
        expect_wr(8, 'hA2);
        expect_wr(9, 'hA3);
        tick();
        chk("drain7_addr", 64'(rf_waddr), 64'd7);
        chk("drain7_stall", 64'(mul_stall), 64'd0);
        tick();
        idle();
        chk("drain8_addr", 64'(rf_waddr), 64'd8);
        tick();
        chk("drain9_we", 64'(rf_we), 64'd1);
        chk("drain9_addr", 64'(rf_waddr), 64'd9);
        chk("drain9_data", 64'(rf_wdata), 64'hA3);
        tick();
        chk("drain_done_we", 64'(rf_we), 64'd0);

        // WAW squash of a queued entry by a later main write.
        drive(1'b1, 1'b0, 20, 0, 'h2020, 1'b1, 4, 'h44);
        expect_wr(20, 'h2020);
        tick();
        chk("squash_pre_mask", 64'(pending_mask), 64'(1 << 4));
        drive(1'b1, 1'b0, 4, 0, 'h4444, 1'b0, 0, 0);
        expect_wr(4, 'h4444);
        tick();
        chk("squash_mask", 64'(pending_mask), 64'd0);
        chk("squash_main_data", 64'(rf_wdata), 64'h4444);
        idle();
        tick();
        chk("squash_silent_pop", 64'(rf_we), 64'd0);
        tick();
        chk("squash_idle", 64'(rf_we), 64'd0);

        // Same-cycle collision on rd=6: multiplier result dropped.
        drive(1'b1, 1'b0, 6, 0, 'h600, 1'b1, 6, 'h6FF);
        expect_wr(6, 'h600);
        tick();
        chk("collide_data", 64'(rf_wdata), 64'h600);
        chk("collide_stall", 64'(mul_stall), 64'd0);
        chk("collide_mask", 64'(pending_mask), 64'd0);
        idle();
        tick();
        chk("collide_no_mul_write", 64'(rf_we), 64'd0);
        tick();

        // Fill the queue, then reset mid-cycle.
        drive(1'b1, 1'b0, 21, 0, 'h21, 1'b1, 22, 'h22);
        expect_wr(21, 'h21);
        tick();
        drive(1'b1, 1'b0, 23, 0, 'h23, 1'b1, 24, 'h24);
        expect_wr(23, 'h23);
        tick();
        idle();
        chk("full_stall", 64'(mul_stall), 64'd1);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_rf_we", 64'(rf_we), 64'd0);
        chk("midrst_rf_waddr", 64'(rf_waddr), 64'd0);
        chk("midrst_rf_wdata", 64'(rf_wdata), 64'd0);
        chk("midrst_stall", 64'(mul_stall), 64'd0);
        chk("midrst_mask", 64'(pending_mask), 64'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("postrst%0d_we", i), 64'(rf_we), 64'd0);
        end
        chk("postrst_mask", 64'(pending_mask), 64'd0);
        chk("sb_empty", 64'(sb.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
